// File: rtl/unpadder.sv
// SHA-2 unpadder: strips padding from 512/1024-bit blocks and replays the
// original byte-granular message on an AXI-Stream master with tkeep/tlast.
module unpadder #(
  parameter int P_M_AXIS_DATA_WIDTH = 512,
  parameter int P_S_AXIS_DATA_WIDTH = 512,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                             axi_aclk,
  input  logic                             axi_reset,
  input  logic [1:0]                       sha_type,
  input  logic [P_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [P_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [P_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser
);

  localparam int DW = P_S_AXIS_DATA_WIDTH;
  localparam int KW = P_M_AXIS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TERM  = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic                 k2_r;
  logic [DW-1:0]        buf_r [0:3];
  logic [2:0]           count_r;
  logic [CNT_WIDTH-1:0] n_r;
  logic [63:0]          len_r;
  logic                 hi_nz_r;
  logic [63:0]          byte_len_r;
  logic [63:0]          off_r;
  logic                 err_r;

  logic [2:0]    cap_s;
  logic [1:0]    top_idx_s;
  logic          out_free_s;
  logic          accept_s;
  logic [63:0]   blen_s, n_ext_s, head_off_s, exp_beats_s, rel_s, rem_s;
  logic          in_buf_s, err_s, last_s;
  logic [7:0]    marker_s;
  logic [6:0]    v_s;
  logic [KW-1:0] keep_s;
  logic          unused_s;

  function automatic logic [63:0] be64(input logic [63:0] d);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] keep_to_mask(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    m = {DW{1'b0}};
    for (int i = 0; i < KW; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign unused_s   = sha_type[0];
  assign cap_s      = k2_r ? 3'd4 : 3'd2;
  assign top_idx_s  = k2_r ? 2'd3 : 2'd1;
  assign out_free_s = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = (state_r == ST_FILL) & ((count_r < cap_s) | out_free_s);
  assign accept_s   = s_axis_tvalid & s_axis_tready;

  // Padding validation terms, evaluated while in CHECK
  assign blen_s      = {3'b000, len_r[63:3]};
  assign n_ext_s     = {{(64-CNT_WIDTH){1'b0}}, n_r};
  assign head_off_s  = (n_ext_s - {61'd0, count_r}) << 6;
  assign exp_beats_s = k2_r ? (((blen_s + 64'd144) >> 7) << 1) : ((blen_s + 64'd72) >> 6);
  assign rel_s       = blen_s - head_off_s;
  assign in_buf_s    = (blen_s >= head_off_s) && (rel_s < {55'd0, count_r, 6'd0});
  assign marker_s    = buf_r[rel_s[7:6]][{rel_s[5:0], 3'b000} +: 8];
  assign err_s       = (len_r[2:0] != 3'd0) | (k2_r & n_r[0]) | (n_ext_s != exp_beats_s) |
                       (k2_r & hi_nz_r) | ~in_buf_s | (marker_s != 8'h80);

  // Valid bytes of the buffer head while draining
  assign rem_s  = byte_len_r - off_r;
  assign v_s    = (byte_len_r <= off_r) ? 7'd0 : ((rem_s >= 64'd64) ? 7'd64 : rem_s[6:0]);
  assign keep_s = (v_s == 7'd64) ? {KW{1'b1}} : ((64'd1 << v_s) - 64'd1);
  assign last_s = (off_r + 64'd64) >= byte_len_r;

  // State register
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state_r <= ST_IDLE;
    else           state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = ST_FILL;
      ST_FILL: begin
        if (accept_s && s_axis_tlast) state_s = ST_CHECK;
        else                          state_s = ST_FILL;
      end
      ST_CHECK: begin
        if (err_s || (blen_s == 64'd0)) state_s = ST_TERM;
        else                            state_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_r == 3'd0)                                   state_s = ST_IDLE;
        else if (out_free_s && (v_s != 7'd0) && last_s)        state_s = ST_IDLE;
        else                                                   state_s = ST_DRAIN;
      end
      ST_TERM: begin
        if (out_free_s) state_s = ST_IDLE;
        else            state_s = ST_TERM;
      end
      default:  state_s = ST_IDLE;
    endcase
  end

  // Holdback buffer, counters and registered output beat
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      k2_r          <= 1'b0;
      count_r       <= 3'd0;
      n_r           <= {CNT_WIDTH{1'b0}};
      len_r         <= 64'd0;
      hi_nz_r       <= 1'b0;
      byte_len_r    <= 64'd0;
      off_r         <= 64'd0;
      err_r         <= 1'b0;
      for (int i = 0; i < 4; i++) buf_r[i] <= {DW{1'b0}};
      m_axis_tdata  <= {P_M_AXIS_DATA_WIDTH{1'b0}};
      m_axis_tkeep  <= {KW{1'b0}};
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          k2_r    <= sha_type[1];
          n_r     <= {CNT_WIDTH{1'b0}};
          count_r <= 3'd0;
          err_r   <= 1'b0;
        end
        ST_FILL: begin
          if (accept_s) begin
            n_r     <= n_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            len_r   <= be64(s_axis_tdata[DW-1 -: 64]);
            hi_nz_r <= |s_axis_tdata[DW-65 -: 64];
            if (count_r == cap_s) begin
              // Buffer full: the oldest beat can no longer hold padding
              m_axis_tdata  <= buf_r[0];
              m_axis_tkeep  <= {KW{1'b1}};
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= 1'b0;
              m_axis_tvalid <= 1'b1;
              for (int i = 0; i < 3; i++) buf_r[i] <= buf_r[i+1];
              buf_r[top_idx_s] <= s_axis_tdata;
            end else begin
              buf_r[count_r[1:0]] <= s_axis_tdata;
              count_r <= count_r + 3'd1;
            end
          end
        end
        ST_CHECK: begin
          err_r      <= err_s;
          byte_len_r <= blen_s;
          off_r      <= head_off_s;
        end
        ST_DRAIN: begin
          if (out_free_s && (count_r != 3'd0)) begin
            for (int i = 0; i < 3; i++) buf_r[i] <= buf_r[i+1];
            count_r <= count_r - 3'd1;
            off_r   <= off_r + 64'd64;
            if (v_s != 7'd0) begin
              m_axis_tdata  <= buf_r[0] & keep_to_mask(keep_s);
              m_axis_tkeep  <= keep_s;
              m_axis_tlast  <= last_s;
              m_axis_tuser  <= 1'b0;
              m_axis_tvalid <= 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (out_free_s) begin
            m_axis_tdata  <= {P_M_AXIS_DATA_WIDTH{1'b0}};
            m_axis_tkeep  <= {KW{1'b0}};
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= err_r;
            m_axis_tvalid <= 1'b1;
          end
        end
        default: begin
          count_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unpadder.sv
// Scoreboard bench for unpadder: builds padded blocks from messages, predicts
// the unpadded beats independently and checks them as the DUT emits them.
module tb_unpadder;

  logic         clk;
  logic         axi_reset;
  logic [1:0]   sha_type;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         m_axis_tuser;

  unpadder dut (
    .axi_aclk      (clk),
    .axi_reset     (axi_reset),
    .sha_type      (sha_type),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
  } exp_t;

  exp_t         exp_q [$];
  exp_t         mon_e;
  logic [511:0] beats_q [$];
  logic [7:0]   msg   [0:1023];
  logic [7:0]   pad_b [0:1023];
  int           compared;
  int           mismatched;
  int           rdy_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = stalled
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] expv);
    compared++;
    assert (got === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // Output monitor: compare every accepted beat against the scoreboard head
  always @(negedge clk) begin
    if (!axi_reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {511'd0, m_axis_tvalid}, 512'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("tdata", m_axis_tdata, mon_e.data);
        check("tkeep", {448'd0, m_axis_tkeep}, {448'd0, mon_e.keep});
        check("tlast", {511'd0, m_axis_tlast}, {511'd0, mon_e.last});
        check("tuser", {511'd0, m_axis_tuser}, {511'd0, mon_e.user});
      end
    end
  end

  task automatic make_msg(input int n, input int seed);
    for (int i = 0; i < n; i++) msg[i] = 8'((i * 37 + seed) & 255);
  endtask

  task automatic set_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  // Pad msg[0:n-1] into 64-byte beats (K=2 when k2)
  task automatic build(input int n, input bit k2);
    int kb, lf, nblk, total;
    logic [63:0] lbits;
    logic [511:0] b;
    kb = k2 ? 128 : 64;
    lf = k2 ? 16 : 8;
    nblk = (n + 1 + lf + kb - 1) / kb;
    total = nblk * kb;
    lbits = 64'(n) * 64'd8;
    for (int i = 0; i < total; i++) pad_b[i] = 8'h00;
    for (int i = 0; i < n; i++) pad_b[i] = msg[i];
    pad_b[n] = 8'h80;
    for (int i = 0; i < 8; i++) pad_b[total-1-i] = lbits[8*i +: 8];
    beats_q.delete();
    for (int j = 0; j < total / 64; j++) begin
      b = 512'd0;
      for (int i = 0; i < 64; i++) b[8*i +: 8] = pad_b[64*j + i];
      beats_q.push_back(b);
    end
  endtask

  task automatic expect_msg(input int n);
    exp_t e;
    int v;
    if (n == 0) begin
      e = '{data: 512'd0, keep: 64'd0, last: 1'b1, user: 1'b0};
      exp_q.push_back(e);
    end else begin
      for (int off = 0; off < n; off += 64) begin
        v = (n - off > 64) ? 64 : n - off;
        e = '{data: 512'd0, keep: 64'd0, last: (off + 64 >= n), user: 1'b0};
        for (int i = 0; i < v; i++) begin
          e.keep[i] = 1'b1;
          e.data[8*i +: 8] = msg[off + i];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic expect_err();
    exp_t e;
    e = '{data: 512'd0, keep: 64'd0, last: 1'b1, user: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic [511:0] d, input bit last, input bit rnd);
    bit hs;
    int gap;
    hs = 1'b0;
    if (rnd) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (s_axis_tready) begin hs = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("send_handshake", {511'd0, hs}, 512'd1);
  endtask

  task automatic send_all(input bit rnd);
    for (int j = 0; j < beats_q.size(); j++) send_beat(beats_q[j], (j == beats_q.size() - 1), rnd);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(tag, {511'd0, (exp_q.size() == 0)}, 512'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_tready"}, {511'd0, s_axis_tready}, 512'd0);
    check({tag, "_m_tvalid"}, {511'd0, m_axis_tvalid}, 512'd0);
    check({tag, "_m_tlast"},  {511'd0, m_axis_tlast},  512'd0);
    check({tag, "_m_tuser"},  {511'd0, m_axis_tuser},  512'd0);
    check({tag, "_m_tkeep"},  {448'd0, m_axis_tkeep},  512'd0);
    check({tag, "_m_tdata"},  m_axis_tdata,            512'd0);
  endtask

  initial begin
    logic [511:0] tmp;
    compared      = 0;
    mismatched    = 0;
    rdy_mode      = 0;
    axi_reset     = 1'b1;
    sha_type      = 2'd0;
    s_axis_tdata  = 512'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    axi_reset = 1'b0;

    // SHA-256 "abc"
    set_abc(); build(3, 1'b0); expect_msg(3); send_all(1'b0); wait_drain("abc256_done");
    // 56-byte message spilling padding into a second block
    make_msg(56, 5); build(56, 1'b0); expect_msg(56); send_all(1'b1); wait_drain("m56_done");
    // 300-byte message with toggling downstream ready and random source gaps
    rdy_mode = 1;
    make_msg(300, 9); build(300, 1'b0); expect_msg(300); send_all(1'b1); wait_drain("m300_done");
    rdy_mode = 0;

    // Error: missing 0x80 marker
    set_abc(); build(3, 1'b0);
    tmp = beats_q[0]; tmp[31:24] = 8'h00; beats_q[0] = tmp;
    expect_err(); send_all(1'b0); wait_drain("err_marker_done");
    // Error: length not a whole number of bytes
    set_abc(); build(3, 1'b0);
    tmp = beats_q[0]; tmp[511:504] = 8'h19; beats_q[0] = tmp;
    expect_err(); send_all(1'b0); wait_drain("err_len19_done");
    // Error: extra block for a 3-byte length
    set_abc(); build(3, 1'b0); beats_q.push_back(beats_q[0]);
    expect_err(); send_all(1'b0); wait_drain("err_blocks_done");
    // Empty message
    build(0, 1'b0); expect_msg(0); send_all(1'b0); wait_drain("empty_done");

    // Reset while the drain is stalled by downstream
    make_msg(300, 3); build(300, 1'b0); expect_msg(300); send_all(1'b0);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    check("stalled_valid", {511'd0, m_axis_tvalid}, 512'd1);
    axi_reset = 1'b1;
    @(posedge clk);
    #1;
    axi_reset = 1'b0;
    check_idle_outputs("midreset");
    exp_q.delete();
    rdy_mode = 0;
    set_abc(); build(3, 1'b0); expect_msg(3); send_all(1'b0); wait_drain("post_reset_done");

    // SHA-512: type latched in IDLE after reset
    sha_type  = 2'd2;
    axi_reset = 1'b1;
    @(posedge clk);
    #1;
    axi_reset = 1'b0;
    set_abc(); build(3, 1'b1); expect_msg(3);
    send_beat(beats_q[0], 1'b0, 1'b0);
    sha_type = 2'd0;
    send_beat(beats_q[1], 1'b1, 1'b0);
    sha_type = 2'd2;
    wait_drain("abc512_done");
    rdy_mode = 1;
    make_msg(130, 11); build(130, 1'b1); expect_msg(130); send_all(1'b1); wait_drain("m130_512_done");
    rdy_mode = 0;

    repeat (10) @(posedge clk);
    #1;
    check("leftover_expected", 512'(exp_q.size()), 512'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/unpadder.md
# unpadder

Receive-side counterpart of the SHA-2 padder: consumes a stream of padded 512-bit message blocks (SHA-224/256) or 1024-bit blocks carried as 512-bit beat pairs (SHA-384/512), validates the padding and length field, and reproduces the original byte-granular message on an AXI-Stream master with tkeep/tlast. Sits between the block stream (loopback/verification path or any block-formatted source) and byte-oriented consumers.

## Interface
- P_M_AXIS_DATA_WIDTH, 512, master tdata width; fixed 512
- P_S_AXIS_DATA_WIDTH, 512, slave tdata width; fixed 512
- CNT_WIDTH, 32, beat counter width; messages limited to 2^CNT_WIDTH-1 beats
- axi_aclk  in  1  clock; one clock domain
- axi_reset  in  1  synchronous, active-high reset
- sha_type  in  2  bit1=1: SHA-384/512 (K=2 beats/block), else K=1; sampled in IDLE only
- s_axis_tdata  in  512  padded block beat; byte i at [8i+7:8i]
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready
- s_axis_tlast  in  1  last beat of final block
- m_axis_tdata  out  512  message bytes; bytes beyond tkeep forced to 0
- m_axis_tkeep  out  64  contiguous low-aligned byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output accept
- m_axis_tlast  out  1  last beat of message
- m_axis_tuser  out  1  padding error; valid only with tlast

## Operation
- Block framing: length field big-endian in last 8 bytes of block (bytes 56..63, byte 56 = MSB) for K=1; last 16 bytes of the 1024-bit block (beat 2 bytes 48..63) for K=2, upper 64 bits must be zero. L = bit length, B = L/8.
- Holdback buffer: 2K beats (final and penultimate block can hold message tail). Output register separate; out_free = ~m_axis_tvalid | m_axis_tready.
- States: IDLE, FILL, CHECK, DRAIN, TERM.
- IDLE: latch sha_type, clear beat counter N, buffer empty; next cycle -> FILL.
- FILL: s_axis_tready = (count<2K) | out_free. Accepted beat pushed; if buffer held 2K beats, oldest moves to output register with tkeep=all ones, tlast=0, tuser=0. N increments per accepted beat. Accepted beat with tlast -> CHECK.
- CHECK (1 cycle, s_axis_tready=0): error if any of: L[2:0]!=0; N not multiple of K; N != K*ceil((B+1+8K)/(64K)); upper 64 length bits nonzero (K=2); byte at global offset B != 0x80. Global offset of buffer head = (N - count)*64. Error or B==0 -> TERM; else -> DRAIN.
- DRAIN: each cycle with out_free, pop head; valid bytes v = clamp(B - offset, 0, 64). v>0: load output, tkeep=(1<<v)-1, data masked, tlast=1 when offset+64>=B. v==0: discard, no output. After tlast beat loaded -> IDLE; remaining buffered beats discarded.
- TERM: when out_free, load tdata=0, tkeep=0, tlast=1, tuser=error; -> IDLE. Buffered beats discarded; beats already forwarded in FILL stand.
- sha_type changes outside IDLE ignored.

## Timing
- Reset: state IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tkeep=0, m_axis_tdata=0, counters 0, buffer empty. Reset mid-message drops everything, including a pending output beat.
- Output is registered; m_axis_* stable while tvalid&~tready.
- FILL full-throughput: one beat in, one beat out per cycle once buffer holds 2K beats and downstream ready.
- First beat forwarded 1 cycle after the (2K+1)th beat handshake.
- tlast accepted at edge E0: CHECK during E0->E1, DRAIN/TERM from E1, first drained/terminator beat valid after E2 if out_free.
- Each discarded beat costs one DRAIN cycle.
- IDLE always lasts one cycle; s_axis_tready low in IDLE, CHECK, DRAIN, TERM.

## Test plan
- SHA-256 "abc": one beat, bytes 0..3 = 61 62 63 80, byte 63 = 0x18, tlast -> one beat tkeep=0x7, tdata[23:0]=0x636261, tlast=1, tuser=0.
- SHA-256 56-byte message, two blocks (byte 56 of block 0 = 0x80, block 1 length 0x1C0) -> one beat tkeep=2^56-1, tlast=1; block 1 discarded.
- SHA-256 300-byte message, 5 blocks, m_axis_tready toggling 1010..., s_axis_tvalid random -> 4 full beats then tkeep=2^44-1, tlast=1; bytes match, no drops/duplicates.
- SHA-512 "abc": 2 beats, beat 2 byte 63 = 0x18 -> one beat tkeep=0x7, tlast=1; beat 2 discarded; sha_type toggled mid-message has no effect.
- Errors, SHA-256: length 0x18 with byte 3 = 0x00; length 0x19; 2 blocks with length 0x18 -> single beat tkeep=0, tlast=1, tuser=1 each.
- Empty message: byte 0 = 0x80, length 0 -> tkeep=0, tlast=1, tuser=0; then axi_reset asserted during DRAIN of 300-byte case -> all outputs 0 next cycle, next message correct.
